keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter NROWS, default 4, number of driven row lines, legal range 2..8.
REQ-002 Parameter NCOLS, default 4, number of sensed column lines, legal range 2..8.
REQ-003 Parameter SETTLE_CYCLES, default 4, cycles each row is driven before columns are sampled, minimum 1.
REQ-004 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required for press or release, minimum 1.
REQ-005 Port clk, input, 1, sole clock; all state SHALL update on the rising edge.
REQ-006 Port reset, input, 1, asynchronous active-low reset.
REQ-007 Port col, input, NCOLS, active-high column sense; bit c high means a key in the driven row and column c is closed.
REQ-008 Port row, output, NROWS, one-hot active-high row drive.
REQ-009 Port key_code, output, CW = max(1, clog2(NROWS*NCOLS)), encoded key as row_index*NCOLS + col_index.
REQ-010 Port key_valid, output, 1, key_code holds an unconsumed press event.
REQ-011 Port key_ready, input, 1, consumer accepts the event in any cycle where key_valid and key_ready are both high.
REQ-012 Port key_held, output, 1, a debounced key is currently down.

Function
REQ-013 The FSM SHALL have states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-014 In SCAN, the FSM SHALL drive row bit r for SETTLE_CYCLES cycles, then sample col in the last cycle.
REQ-015 On a SCAN sample with col all zero, r SHALL advance to (r+1) mod NROWS, wrapping from NROWS-1 to 0.
REQ-016 On a SCAN sample with any col bit high, the FSM SHALL latch r and the lowest set column index c, then enter DEBOUNCE with r still driven.
REQ-017 In DEBOUNCE, the FSM SHALL count cycles where col[c] is high; if col[c] goes low before the count reaches DEBOUNCE_CYCLES, the counter SHALL clear and the FSM SHALL return to SCAN on the same row.
REQ-018 On reaching DEBOUNCE_CYCLES in DEBOUNCE, the FSM SHALL enter PRESSED, register key_code = r*NCOLS+c, and set key_valid=1 and key_held=1 in the same cycle.
REQ-019 key_valid SHALL stay high, with key_code unchanged, until the first cycle where key_ready is high; it SHALL clear on the following edge.
REQ-020 Exactly one event SHALL be generated per debounced press; other keys closed while in PRESSED or RELEASE SHALL be ignored (no rollover).
REQ-021 In PRESSED, when col[c] goes low the FSM SHALL enter RELEASE.
REQ-022 In RELEASE, the FSM SHALL count consecutive low cycles of col[c]; if col[c] returns high before DEBOUNCE_CYCLES, the FSM SHALL return to PRESSED.
REQ-023 On reaching DEBOUNCE_CYCLES in RELEASE, key_held SHALL clear; the FSM SHALL enter SCAN at row (r+1) mod NROWS only once key_valid is 0, and otherwise remain in RELEASE with row held.
REQ-024 A key_ready high while key_valid is low SHALL have no effect.
REQ-025 The row output SHALL be exactly one-hot in every cycle, including during and after reset.
REQ-026 Settle and debounce counters SHALL be sized clog2(max+1) and SHALL never wrap.

Reset
REQ-027 While reset is low, the block SHALL be held asynchronously in: state SCAN, r=0, row=one-hot bit 0, key_code=0, key_valid=0, key_held=0, all counters 0.
REQ-028 A reset asserted in any state, including with key_valid high, SHALL discard the pending event.
REQ-029 Scanning SHALL start on the first rising edge after reset deasserts.

Configuration
REQ-030 When KEYPAD_SYNC_EN is defined, col SHALL pass through a two-flop synchronizer (reset to 0) before all FSM logic, adding exactly 2 cycles to every col-to-response latency.
REQ-031 When KEYPAD_SYNC_EN is undefined, col SHALL feed the FSM directly and the synchronizer flops SHALL be absent.

Verification (defaults, KEYPAD_SYNC_EN undefined)
REQ-032 Idle scan: col=0 after reset -> row follows 0001, 0010, 0100, 1000, 0001, with each value held for 4 cycles.
REQ-033 Clean press: col=0010 whenever row=0100, held 60 cycles, key_ready=1 -> a single key_valid for one cycle with key_code=9; key_held high from debounce until 16 cycles after col drops.
REQ-034 Bounce: col=0001 for 5 cycles during the row 0 window -> no key_valid; row stays 0001 and scanning resumes from row 0.
REQ-035 Backpressure: press and release key 9 with key_ready=0 for 100 cycles -> key_valid stays 1 with key_code=9 stable, row stays 0100; after one key_ready=1 cycle, key_valid drops and row advances to 1000.
REQ-036 Multi-key: col=1010 on row 1 -> key_code=5 (lowest column wins); adding col bit 3 during PRESSED produces no second event.
REQ-037 Reset mid-press: reset low while key_valid=1 -> key_valid=0, key_held=0 and row=0001 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/keypad_scanner.sv
// Row-scanning matrix keypad controller with press/release debounce and a valid/ready event port.
// Define KEYPAD_SYNC_EN to pass col through a two-flop synchronizer before the FSM.
module keypad_scanner #(
   parameter int NROWS           = 4,
   parameter int NCOLS           = 4,
   parameter int SETTLE_CYCLES   = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   localparam int CW = ($clog2(NROWS * NCOLS) > 1) ? $clog2(NROWS * NCOLS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCOLS-1:0] col,
   output logic [NROWS-1:0] row,
   output logic [CW-1:0]    key_code,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             key_held
);

   localparam int RW  = $clog2(NROWS);
   localparam int CLW = $clog2(NCOLS);
   localparam int SW  = $clog2(SETTLE_CYCLES + 1);
   localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

   state_t           state, state_nxt;
   logic [RW-1:0]    r, r_nxt, r_inc;
   logic [CLW-1:0]   c, c_nxt, c_low;
   logic [SW-1:0]    settle_cnt, settle_nxt;
   logic [DW-1:0]    deb_cnt, deb_nxt;
   logic [CW-1:0]    code_nxt;
   logic             valid_nxt, held_nxt;
   logic [NCOLS-1:0] col_f;
   logic             col_hit, found;

`ifdef KEYPAD_SYNC_EN
   logic [NCOLS-1:0] col_s1, col_s2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_s1 <= '0;
         col_s2 <= '0;
      end else begin
         col_s1 <= col;
         col_s2 <= col_s1;
      end
   end

   assign col_f = col_s2;
`else
   assign col_f = col;
`endif

   always_comb begin
      c_low = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NCOLS; i++) begin
         if (col_f[i] && !found) begin
            c_low = CLW'(i);
            found = 1'b1;
         end
      end
   end

   // Row drive is a pure decode of r, so it is one-hot even while reset is held.
   always_comb begin
      row    = '0;
      row[r] = 1'b1;
   end

   assign col_hit = col_f[c];
   assign r_inc   = (r == RW'(NROWS - 1)) ? '0 : r + 1'b1;

   always_comb begin
      state_nxt  = state;
      r_nxt      = r;
      c_nxt      = c;
      settle_nxt = settle_cnt;
      deb_nxt    = deb_cnt;
      code_nxt   = key_code;
      held_nxt   = key_held;
      valid_nxt  = key_valid & ~key_ready;
      unique case (state)
         SCAN: begin
            if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
               settle_nxt = '0;
               if (|col_f) begin
                  c_nxt     = c_low;
                  deb_nxt   = '0;
                  state_nxt = DEBOUNCE;
               end else begin
                  r_nxt = r_inc;
               end
            end else begin
               settle_nxt = settle_cnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (!col_hit) begin
               deb_nxt   = '0;
               state_nxt = SCAN;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               deb_nxt   = '0;
               state_nxt = PRESSED;
               code_nxt  = CW'(int'(r) * NCOLS + int'(c));
               valid_nxt = 1'b1;
               held_nxt  = 1'b1;
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!col_hit) begin
               deb_nxt   = '0;
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            // A saturated count means the release is already debounced; only the
            // pending event can still hold the scanner on this row.
            if (deb_cnt == DW'(DEBOUNCE_CYCLES)) begin
               if (!key_valid) begin
                  deb_nxt   = '0;
                  r_nxt     = r_inc;
                  state_nxt = SCAN;
               end
            end else if (col_hit) begin
               deb_nxt   = '0;
               state_nxt = PRESSED;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               held_nxt = 1'b0;
               if (!key_valid) begin
                  deb_nxt   = '0;
                  r_nxt     = r_inc;
                  state_nxt = SCAN;
               end else begin
                  deb_nxt = DW'(DEBOUNCE_CYCLES);
               end
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= SCAN;
         r          <= '0;
         c          <= '0;
         settle_cnt <= '0;
         deb_cnt    <= '0;
         key_code   <= '0;
         key_valid  <= 1'b0;
         key_held   <= 1'b0;
      end else begin
         state      <= state_nxt;
         r          <= r_nxt;
         c          <= c_nxt;
         settle_cnt <= settle_nxt;
         deb_cnt    <= deb_nxt;
         key_code   <= code_nxt;
         key_valid  <= valid_nxt;
         key_held   <= held_nxt;
      end
   end

endmodule
